key_expand_multi: RTL

Iterative AES key-expansion engine supporting 128-, 192- and 256-bit cipher keys, selectable per operation. It generates one 32-bit schedule word per clock and emits a 128-bit round key, with its index, every fourth word. It sits between the key-load path and the round-key store of the cipher core, and supersedes the fixed AES-128 round-key generator.

---
 rtl/key_expand_multi.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/key_expand_multi.sv
// AES-128/192/256 key schedule: one 32-bit word per clock, 128-bit round key every fourth word.
// Round key j strobes 4j+4 cycles after the accepting edge; start is ignored while busy, rejected lengths pulse err.
module key_expand_multi #(
  parameter logic [2:0] MODE_EN = 3'b111
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, LOAD, GEN} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_t             state_q, state_d;
  logic [255:0]       key_q, key_d;
  logic [2:0]         nkm1_q, nkm1_d;
  logic [5:0]         last_q, last_d;
  logic [5:0]         i_q, i_d;
  logic [2:0]         mod_q, mod_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [7:0][31:0]   hist_q, hist_d;
  logic [2:0][31:0]   asm_q, asm_d;
  logic [127:0]       rk_q, rk_d;
  logic [3:0]         rk_idx_q, rk_idx_d;
  logic               rk_valid_q, rk_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               len_ok;
  logic [2:0]         len_nkm1;
  logic [5:0]         len_last;
  logic [31:0]        w_prev, sub_in, sub_out, t_word, new_w;

  always_comb begin
    len_ok   = 1'b0;
    len_nkm1 = 3'd3;
    len_last = 6'd43;
    case (key_len)
      2'b00: begin len_ok = MODE_EN[0]; len_nkm1 = 3'd3; len_last = 6'd43; end
      2'b01: begin len_ok = MODE_EN[1]; len_nkm1 = 3'd5; len_last = 6'd51; end
      2'b10: begin len_ok = MODE_EN[2]; len_nkm1 = 3'd7; len_last = 6'd59; end
      default: len_ok = 1'b0;
    endcase
  end

  // hist_q[k] holds w[i-1-k], so w[i-Nk] sits at index Nk-1.
  always_comb begin
    w_prev  = hist_q[0];
    sub_in  = (mod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = sub_word(sub_in);
    if (mod_q == 3'd0)
      t_word = sub_out ^ {rcon_q, 24'h0};
    else if (nkm1_q == 3'd7 && mod_q == 3'd4)
      t_word = sub_out;
    else
      t_word = w_prev;
    new_w = (state_q == LOAD) ? key_q[255:224] : (hist_q[nkm1_q] ^ t_word);
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    nkm1_d     = nkm1_q;
    last_d     = last_q;
    i_d        = i_q;
    mod_d      = mod_q;
    rcon_d     = rcon_q;
    hist_d     = hist_q;
    asm_d      = asm_q;
    rk_d       = rk_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d = LOAD;
            key_d   = key;
            nkm1_d  = len_nkm1;
            last_d  = len_last;
            i_d     = 6'd0;
            mod_d   = 3'd0;
            rcon_d  = 8'h01;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD, GEN: begin
        hist_d = {hist_q[6:0], new_w};
        key_d  = key_q << 32;
        i_d    = i_q + 6'd1;
        mod_d  = (mod_q == nkm1_q) ? 3'd0 : mod_q + 3'd1;
        if (state_q == GEN && mod_q == 3'd0)
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        case (i_q[1:0])
          2'd0: asm_d[0] = new_w;
          2'd1: asm_d[1] = new_w;
          2'd2: asm_d[2] = new_w;
          default: begin
            rk_d       = {asm_q[0], asm_q[1], asm_q[2], new_w};
            rk_idx_d   = i_q[5:2];
            rk_valid_d = 1'b1;
          end
        endcase
        if (i_q == last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (state_q == LOAD && i_q == {3'd0, nkm1_q}) begin
          state_d = GEN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      key_q      <= '0;
      nkm1_q     <= 3'd3;
      last_q     <= 6'd43;
      i_q        <= '0;
      mod_q      <= '0;
      rcon_q     <= 8'h01;
      hist_q     <= '0;
      asm_q      <= '0;
      rk_q       <= '0;
      rk_idx_q   <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      nkm1_q     <= nkm1_d;
      last_q     <= last_d;
      i_q        <= i_d;
      mod_q      <= mod_d;
      rcon_q     <= rcon_d;
      hist_q     <= hist_d;
      asm_q      <= asm_d;
      rk_q       <= rk_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = rk_valid_q;
  assign rk_idx   = rk_idx_q;
  assign rk       = rk_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
